mix_columns_iter: RTL
=====================

Name: mix_columns_iter

Overview:
- Iterative AES-128 MixColumns stage. Sits directly downstream of the ShiftRows stage and consumes its 128-bit state.
- Processes COLS_PER_CYCLE columns per clock over a shared GF(2^8) datapath, using a valid/ready handshake on both sides.
- A per-transaction bypass flag passes the state through unchanged for the final AES round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error. NCYC = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  stage can accept a state
- in_data  input  128  ShiftRows output state
- in_bypass  input  1  final round: skip MixColumns, sampled with in_data
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  128  mixed (or bypassed) state
- busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- State layout is column-major. Column c (0..3) occupies bits [127-32c -: 32]. Row r of that column is at [127-32c-8r -: 8]; row 0 is the most significant byte.
- Mixing per column, with input bytes a0..a3 and output bytes b0..b3:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Arithmetic rules: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). 3x = xtime(x)^x. All arithmetic is 8-bit XOR; there is no carry.
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; column counter = 0.
  - State register = 0, out_data = 0, out_valid = 0, busy = 0.
  - in_ready = 1 (it is combinational from IDLE).
- Reset asserted mid-operation aborts the transaction. No output is produced for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the state register and clear the column counter. If in_bypass=1, go to DONE; otherwise go to CALC.
  - CALC: each cycle, replace columns cnt..cnt+COLS_PER_CYCLE-1 in the state register with their mixed values, then advance cnt by COLS_PER_CYCLE (mod 4). When cnt+COLS_PER_CYCLE = 4, go to DONE. in_ready=0.
  - DONE: out_valid=1 and out_data = state register, both held stable until out_ready. On out_valid&&out_ready, go to IDLE. in_ready=0.
- Latency, measured from the accepting edge to out_valid rising:
  - NCYC cycles for a mixed transaction (4, 2 or 1).
  - 1 cycle for a bypassed transaction.
- Throughput: one transaction per NCYC+2 cycles with out_ready held high. There is no overlap of accept and deliver.
- Columns are written in place. Unprocessed columns must still hold their captured values.
- Handshake rules:
  - in_data and in_bypass are sampled only on the accepting edge. Input changes at any other time are ignored.
  - out_ready low in DONE stalls indefinitely with the output stable.
  - out_ready high outside DONE has no effect.
  - in_valid outside IDLE is ignored (not queued).
- out_data holds the last delivered value after returning to IDLE. It changes only as the state register updates.

Test Plan:
- FIPS-197 column vectors, COLS_PER_CYCLE=1, bypass=0:
  - Stimulus: in_data=db135345_f20a225c_01010101_2d26314c.
  - Required: out_data=8e4da1bc_9fdc589d_01010101_4d7ebdf8; out_valid rises exactly 4 cycles after the accepting edge.
- Round-1 vector at COLS_PER_CYCLE=1, 2 and 4:
  - Stimulus: in_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5.
  - Required: out_data=046681e5_e0cb199a_48f8d37a_2806264c; latency 4/2/1 respectively.
- Bypass: in_bypass=1 with the same round-1 input -> out_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5 one cycle after the accepting edge.
- Back-pressure and input stability:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and random in_data throughout.
  - Required: out_valid and out_data stay stable, in_ready=0, and no second capture occurs. Release -> one output beat, then IDLE with in_ready=1.
- Mid-operation reset:
  - Stimulus: pull rst_n low in CALC at cnt=2, asynchronously between edges.
  - Required: out_valid=0, out_data=0, busy=0 and in_ready=1 immediately. A following vector completes correctly.
- Back-to-back traffic: 100 random states with random bypass, in_valid and out_ready -> results match a reference-model scoreboard in order, with no drops or duplicates.

Source files
------------

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: captures a 128-bit state, mixes COLS_PER_CYCLE columns per
// clock in place, then presents the result with a valid/ready handshake (or passes it through on bypass).
module mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_bypass,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
         $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [1:0]   r_cnt;
   logic [127:0] r_data;
   logic [127:0] w_mixed;
   logic         w_last;
   logic         w_accept;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      a0 = a[31:24];
      a1 = a[23:16];
      a2 = a[15:8];
      a3 = a[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Only the columns addressed this cycle change; the rest keep their captured bytes.
   always_comb begin : p_mix
      int c;
      c       = 0;
      w_mixed = r_data;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         c = (int'(r_cnt) + k) % 4;
         w_mixed[127 - 32*c -: 32] = mix_col(r_data[127 - 32*c -: 32]);
      end
   end

   assign w_last   = (int'(r_cnt) + COLS_PER_CYCLE) == 4;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = in_bypass ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_accept) begin
            r_data <= in_data;
            r_cnt  <= 2'd0;
         end else if (r_state == S_CALC) begin
            r_data <= w_mixed;
            r_cnt  <= r_cnt + 2'(COLS_PER_CYCLE);
         end
      end
   end

   assign out_data  = r_data;
   assign busy      = (r_state != S_IDLE);
   assign dbg_state = r_state;

endmodule
